regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_dump_fsm.sv | 78 +++++++
 rtl/regfile_mp.sv | 112 +++++++++++
 tb/tb_regfile_mp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its debug dump.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Debug dump sequencer: streams every register out with a valid/ready handshake.
//
// state  | meaning
// IDLE   | no dump in progress, waiting for start_i
// STREAM | valid_o high, presenting register idx_o until the sink accepts it
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned  XLEN  = XLEN_DEFAULT,
    parameter int unsigned  NREGS = NREGS_DEFAULT,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start_i,
    input  logic            ready_i,
    input  logic [XLEN-1:0] cap_data_i,
    output logic [AW-1:0]   cap_idx_o,
    output logic            valid_o,
    output logic [AW-1:0]   idx_o,
    output logic [XLEN-1:0] data_o,
    output logic            done_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_e     state_q;
    logic [AW-1:0]   idx_q;
    logic [XLEN-1:0] data_q;
    logic            valid_q;
    logic            done_q;

    // The register file returns the post-write value of this index, so a
    // write landing on the capture edge is included in the captured word.
    assign cap_idx_o = (state_q == STREAM) ? idx_q + AW'(1) : '0;

    // Sequencer state, index and registered handshake outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= STREAM;
                        idx_q   <= '0;
                        data_q  <= cap_data_i;
                        valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= cap_idx_o;
                            data_q <= cap_data_i;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;
    assign done_o  = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-write-port register file with x0 hardwired to zero, optional write-to-read
// forwarding, a pending-writeback scoreboard and a debug dump stream.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned  XLEN   = XLEN_DEFAULT,
    parameter int unsigned  NREGS  = NREGS_DEFAULT,
    parameter bit           BYPASS = 1'b1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            dump_start,
    input  logic            dump_ready,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] wr_hit;
    logic             we_a;
    logic             we_b;
    logic [AW-1:0]    cap_idx;
    logic [XLEN-1:0]  cap_data;

    assign we_a = wa_en && (wa_addr != '0);
    assign we_b = wb_en && (wb_addr != '0);

    // Post-write view of every register; port B is applied last so it wins.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            wr_hit[i] = 1'b0;
            if (we_a && (wa_addr == AW'(i))) begin
                regs_d[i] = wa_data;
                wr_hit[i] = 1'b1;
            end
            if (we_b && (wb_addr == AW'(i))) begin
                regs_d[i] = wb_data;
                wr_hit[i] = 1'b1;
            end
        end
    end

    // Writeback clears pending, issue sets it; issue wins on a same-cycle collision.
    always_comb begin
        pend_d = pend_q & ~wr_hit;
        if (iss_en && (iss_rd != '0)) begin
            pend_d[iss_rd] = 1'b1;
        end
    end

    // Storage array and scoreboard.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : (BYPASS ? regs_d[rs1_addr] : regs_q[rs1_addr]);
    assign rs2_data = (rs2_addr == '0) ? '0 : (BYPASS ? regs_d[rs2_addr] : regs_q[rs2_addr]);

    // A same-cycle writeback resolves the hazard only when it can be forwarded.
    assign rs1_busy = (rs1_addr != '0) && pend_q[rs1_addr] && !(BYPASS && wr_hit[rs1_addr]);
    assign rs2_busy = (rs2_addr != '0) && pend_q[rs2_addr] && !(BYPASS && wr_hit[rs2_addr]);

    assign cap_data = regs_d[cap_idx];

    regfile_dump_fsm #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_dump (
        .CLK        (CLK),
        .reset      (reset),
        .start_i    (dump_start),
        .ready_i    (dump_ready),
        .cap_data_i (cap_data),
        .cap_idx_o  (cap_idx),
        .valid_o    (dump_valid),
        .idx_o      (dump_idx),
        .data_o     (dump_data),
        .done_o     (dump_done)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32-entry forwarding build and a 16-entry non-forwarding
// build share one stimulus stream and are compared every cycle against an
// array-based reference model.
module tb_regfile_mp;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset;
    logic [4:0]  rs1_a, rs2_a, wa_a, wb_a, iss_a;
    logic        wa_en, wb_en, iss_en, dstart, dready;
    logic [31:0] wa_d, wb_d;

    logic [31:0] r1_0, r2_0, dd_0;
    logic        b1_0, b2_0, dv_0, dn_0;
    logic [4:0]  di_0;
    logic [31:0] r1_1, r2_1, dd_1;
    logic        b1_1, b2_1, dv_1, dn_1;
    logic [3:0]  di_1;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut32 (
        .CLK(CLK), .reset(reset),
        .rs1_addr(rs1_a), .rs2_addr(rs2_a), .rs1_data(r1_0), .rs2_data(r2_0),
        .wa_en(wa_en), .wa_addr(wa_a), .wa_data(wa_d),
        .wb_en(wb_en), .wb_addr(wb_a), .wb_data(wb_d),
        .iss_en(iss_en), .iss_rd(iss_a), .rs1_busy(b1_0), .rs2_busy(b2_0),
        .dump_start(dstart), .dump_ready(dready), .dump_valid(dv_0),
        .dump_idx(di_0), .dump_data(dd_0), .dump_done(dn_0)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .BYPASS(1'b0)) dut16 (
        .CLK(CLK), .reset(reset),
        .rs1_addr(rs1_a[3:0]), .rs2_addr(rs2_a[3:0]), .rs1_data(r1_1), .rs2_data(r2_1),
        .wa_en(wa_en), .wa_addr(wa_a[3:0]), .wa_data(wa_d),
        .wb_en(wb_en), .wb_addr(wb_a[3:0]), .wb_data(wb_d),
        .iss_en(iss_en), .iss_rd(iss_a[3:0]), .rs1_busy(b1_1), .rs2_busy(b2_1),
        .dump_start(dstart), .dump_ready(dready), .dump_valid(dv_1),
        .dump_idx(di_1), .dump_data(dd_1), .dump_done(dn_1)
    );

    // Reference model, index 0 = 32-entry forwarding build, 1 = 16-entry plain build.
    logic [31:0] mr [2][32];
    bit          mp [2][32];
    logic [31:0] nx [2][32];
    bit          wr [2][32];
    bit          ev [2];
    int          eidx [2];
    logic [31:0] edata [2];
    bit          edone [2];
    int          beats [2];
    int          dones [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nregs(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    task automatic clear_model(input int k);
        for (int i = 0; i < 32; i++) begin
            mr[k][i] = '0; mp[k][i] = 1'b0; nx[k][i] = '0; wr[k][i] = 1'b0;
        end
        ev[k] = 1'b0; eidx[k] = 0; edata[k] = '0; edone[k] = 1'b0;
    endtask

    // Register contents as they stand after this cycle's writes (A first, then B).
    task automatic eval_k(input int k);
        int n = nregs(k);
        int a;
        for (int i = 0; i < 32; i++) begin
            nx[k][i] = mr[k][i];
            wr[k][i] = 1'b0;
        end
        if (!reset) begin
            a = int'(wa_a) % n;
            if (wa_en && a != 0) begin nx[k][a] = wa_d; wr[k][a] = 1'b1; end
            a = int'(wb_a) % n;
            if (wb_en && a != 0) begin nx[k][a] = wb_d; wr[k][a] = 1'b1; end
        end
    endtask

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] addr);
        int a = int'(addr) % nregs(k);
        if (a == 0) return '0;
        return (k == 0) ? nx[k][a] : mr[k][a];
    endfunction

    function automatic bit exp_busy(input int k, input logic [4:0] addr);
        int a = int'(addr) % nregs(k);
        if (a == 0) return 1'b0;
        if (k == 0 && wr[k][a]) return 1'b0;
        return mp[k][a];
    endfunction

    task automatic check_k(input int k);
        logic [31:0] r1, r2, dd;
        logic        b1, b2, dv, dn;
        logic [4:0]  di;
        if (k == 0) begin
            r1 = r1_0; r2 = r2_0; dd = dd_0; b1 = b1_0; b2 = b2_0; dv = dv_0; dn = dn_0; di = di_0;
        end else begin
            r1 = r1_1; r2 = r2_1; dd = dd_1; b1 = b1_1; b2 = b2_1; dv = dv_1; dn = dn_1; di = {1'b0, di_1};
        end
        chk($sformatf("rs1_data%0d", k), r1, exp_rd(k, rs1_a));
        chk($sformatf("rs2_data%0d", k), r2, exp_rd(k, rs2_a));
        chk($sformatf("rs1_busy%0d", k), b1, exp_busy(k, rs1_a));
        chk($sformatf("rs2_busy%0d", k), b2, exp_busy(k, rs2_a));
        chk($sformatf("dump_valid%0d", k), dv, ev[k]);
        chk($sformatf("dump_done%0d", k), dn, edone[k]);
        if (ev[k] || reset) begin
            chk($sformatf("dump_idx%0d", k), di, eidx[k]);
            chk($sformatf("dump_data%0d", k), dd, edata[k]);
        end
        if (dn) dones[k]++;
    endtask

    task automatic commit_k(input int k);
        int n = nregs(k);
        int a;
        if (reset) begin
            clear_model(k);
            return;
        end
        for (int i = 0; i < 32; i++) if (wr[k][i]) mp[k][i] = 1'b0;
        a = int'(iss_a) % n;
        if (iss_en && a != 0) mp[k][a] = 1'b1;
        for (int i = 0; i < 32; i++) mr[k][i] = nx[k][i];
        edone[k] = 1'b0;
        if (!ev[k]) begin
            if (dstart) begin ev[k] = 1'b1; eidx[k] = 0; edata[k] = nx[k][0]; end
        end else if (dready) begin
            beats[k]++;
            if (eidx[k] == n - 1) begin
                ev[k] = 1'b0; edone[k] = 1'b1;
            end else begin
                eidx[k]++; edata[k] = nx[k][eidx[k]];
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin eval_k(k); check_k(k); end
        @(posedge CLK);
        for (int k = 0; k < 2; k++) commit_k(k);
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; iss_en = 0; dstart = 0; dready = 1;
        rs1_a = 0; rs2_a = 0; wa_a = 0; wb_a = 0; iss_a = 0; wa_d = 0; wb_d = 0;
    endtask

    task automatic rand_writes();
        wa_en = 1'($urandom); wa_a = 5'($urandom); wa_d = $urandom;
        wb_en = 1'($urandom); wb_a = 5'($urandom); wb_d = $urandom;
        rs1_a = ($urandom % 4 == 0) ? wa_a : 5'($urandom);
        rs2_a = ($urandom % 4 == 0) ? wb_a : 5'($urandom);
    endtask

    task automatic assert_reset_now();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin clear_model(k); eval_k(k); check_k(k); end
    endtask

    task automatic drain();
        int c = 0;
        idle();
        while ((ev[0] || ev[1]) && c < 100) begin tick(); c++; end
        chk("drain_bound", ev[0] | ev[1], 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [1:0] pat [4];
        idle();
        for (int k = 0; k < 2; k++) begin beats[k] = 0; dones[k] = 0; end
        #2;
        assert_reset_now();
        tick(); tick();
        reset = 1'b0;
        tick();

        // x5 via A, x0 write dropped
        wa_en = 1; wa_a = 5; wa_d = 32'hDEADBEEF; tick();
        idle(); rs1_a = 5; #1;
        chk("x5_read32", r1_0, 32'hDEADBEEF);
        chk("x5_read16", r1_1, 32'hDEADBEEF);
        tick();
        wa_en = 1; wa_a = 0; wa_d = 32'h1; tick();
        idle(); #1;
        chk("x0_read32", r1_0, 0);
        chk("x0_read16", r1_1, 0);
        tick();

        // same-address collision, B wins; forwarding only on the 32-entry build
        wa_en = 1; wa_a = 7; wa_d = 32'h11; wb_en = 1; wb_a = 7; wb_d = 32'h22; rs2_a = 7; #1;
        chk("x7_fwd32", r2_0, 32'h22);
        chk("x7_nofwd16", r2_1, 32'h0);
        tick();
        idle(); rs2_a = 7; #1;
        chk("x7_after32", r2_0, 32'h22);
        chk("x7_after16", r2_1, 32'h22);
        tick();

        // scoreboard
        idle(); iss_en = 1; iss_a = 9; tick();
        idle(); rs1_a = 9; #1;
        chk("busy_iss32", b1_0, 1);
        chk("busy_iss16", b1_1, 1);
        tick();
        wb_en = 1; wb_a = 9; wb_d = 32'h99; rs1_a = 9; #1;
        chk("busy_wb_fwd32", b1_0, 0);
        chk("busy_wb_nofwd16", b1_1, 1);
        tick();
        idle(); rs1_a = 9; #1;
        chk("busy_clr32", b1_0, 0);
        chk("busy_clr16", b1_1, 0);
        tick();
        iss_en = 1; iss_a = 9; wb_en = 1; wb_a = 9; wb_d = 32'h77; rs1_a = 9; tick();
        idle(); rs1_a = 9; #1;
        chk("busy_iss_wb32", b1_0, 1);
        chk("busy_iss_wb16", b1_1, 1);
        tick();

        // random traffic, dumps included
        for (int i = 0; i < 600; i++) begin
            rand_writes();
            iss_en = ($urandom % 3 == 0); iss_a = 5'($urandom);
            dstart = ($urandom % 8 == 0); dready = 1'($urandom);
            tick();
        end
        drain();

        // dump with ready pattern 1,0,0,1 and writes in flight
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        for (int k = 0; k < 2; k++) begin beats[k] = 0; dones[k] = 0; end
        rand_writes(); dstart = 1; dready = 1; tick();
        dstart = 0; c = 0;
        while ((ev[0] || ev[1]) && c < 300) begin
            rand_writes(); dready = pat[c % 4][0]; tick(); c++;
        end
        chk("dump_bound", ev[0] | ev[1], 0);
        idle(); tick(); tick();
        chk("beats32", beats[0], 32);
        chk("beats16", beats[1], 16);
        chk("done_pulses32", dones[0], 1);
        chk("done_pulses16", dones[1], 1);

        // reset in the middle of a dump
        idle(); wa_en = 1; wa_a = 3; wa_d = 32'h5; tick();
        idle(); dstart = 1; tick();
        dstart = 0; c = 0;
        while (eidx[0] != 10 && c < 40) begin tick(); c++; end
        chk("reached_idx10", eidx[0], 10);
        for (int k = 0; k < 2; k++) dones[k] = 0;
        rs1_a = 3;
        assert_reset_now();
        tick(); tick();
        reset = 1'b0;
        rs1_a = 3; #1;
        chk("x3_after_reset32", r1_0, 0);
        chk("x3_after_reset16", r1_1, 0);
        tick(); tick();
        chk("no_done32", dones[0], 0);
        chk("no_done16", dones[1], 0);
        dstart = 1; tick();
        idle(); dready = 0; #1;
        chk("restart_valid32", dv_0, 1);
        chk("restart_idx32", di_0, 0);
        tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
